// File: rtl/mfp_timer_bank.sv
// mfp_timer_bank: a bank of independent MFP68901-style timer channels.
// Each channel has a W-bit down-counter with a reload register, a prescaler,
// and delay, pulse-width and event-count modes. It also offers one-shot
// operation, optional cascading from the previous channel's terminal pulse,
// and a sticky interrupt-pending flag that the bus acknowledges.
//
// Bus interface: SEL, DAT_WE, CTRL_WE, RD_LATCH and IACK are single-cycle
// strobes that are already synchronous to XCLK_I. There is no valid/ready
// handshake. A strobe that is high at a rising edge acts exactly once on
// the channel named by SEL, and the bus is never stalled.
module mfp_timer_bank #(
  parameter int CHANNELS = 4,
  parameter int W        = 8,
  parameter int CASCADE  = 0,
  parameter int SEL_W    = 2
) (
  input  logic                  XCLK_I,
  input  logic                  RST,
  input  logic [SEL_W-1:0]      SEL,
  input  logic                  DAT_WE,
  input  logic [W-1:0]          DAT_I,
  input  logic                  CTRL_WE,
  input  logic [5:0]            CTRL_I,
  output logic [4:0]            CTRL_O,
  input  logic                  RD_LATCH,
  output logic [W-1:0]          DAT_O,
  input  logic                  IACK,
  input  logic [CHANNELS-1:0]   T_I,
  output logic [CHANNELS-1:0]   T_O,
  output logic [CHANNELS-1:0]   T_O_PULSE,
  output logic [CHANNELS-1:0]   IRQ_PEND,
  output logic [CHANNELS-1:0]   DELAY_MODE,
  output logic [CHANNELS*W-1:0] SET_DATA_OUT
);

  // Returns the terminal prescaler value (P-1) for the MFP prescale code.
  function automatic logic [7:0] prescale_last(input logic [2:0] code);
    logic [7:0] last;
    case (code)
      3'd1:    last = 8'd3;
      3'd2:    last = 8'd9;
      3'd3:    last = 8'd15;
      3'd4:    last = 8'd49;
      3'd5:    last = 8'd63;
      3'd6:    last = 8'd99;
      3'd7:    last = 8'd199;
      default: last = 8'd0;
    endcase
    return last;
  endfunction

  logic [CHANNELS-1:0][W-1:0] cnt_vec;
  logic [CHANNELS-1:0][3:0]   ctrl_vec;
  logic [CHANNELS-1:0]        os_vec;
  logic [CHANNELS-1:0]        pulse_vec;
  logic [W-1:0]               sel_cnt;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [W-1:0] data_q;
    logic [W-1:0] cnt_q;
    logic [3:0]   ctrl_q;
    logic         one_shot_q;
    logic [7:0]   psc_q;
    logic         sync1_q;
    logic         sync2_q;
    logic         prev_q;
    logic         t_o_q;
    logic         pulse_q;
    logic         irq_q;

    logic         sel_hit;
    logic         stopped;
    logic         event_mode;
    logic         timed_mode;
    logic         psc_run;
    logic         tick;
    logic         edge_in;
    logic         step;
    logic         terminal;
    logic [7:0]   psc_last;
    logic [W-1:0] reload;

    assign sel_hit    = (SEL == SEL_W'(k));
    assign stopped    = (ctrl_q == 4'b0000);
    assign event_mode = (ctrl_q == 4'b1000);
    assign timed_mode = !stopped && !event_mode;
    assign psc_last   = prescale_last(ctrl_q[2:0]);
    // Pulse mode (ctrl[3] set) only prescales while the synchronised gate is high.
    assign psc_run    = timed_mode && (!ctrl_q[3] || sync2_q);
    // ">=" guards against a stale prescaler left over from a larger prescale code.
    assign tick       = psc_run && (psc_q >= psc_last);
    // Cascaded channels take the registered terminal pulse of their neighbour
    // directly; it is already synchronous, so no extra flops are needed.
    assign edge_in    = (CASCADE != 0 && k > 0) ? pulse_vec[(k > 0) ? k - 1 : 0]
                                                : (sync2_q && !prev_q);
    assign step       = event_mode ? edge_in : tick;
    assign terminal   = step && (cnt_q == W'(1));
    // A data write landing on terminal count reloads the fresh value.
    assign reload     = (DAT_WE && sel_hit) ? DAT_I : data_q;

    // Per-channel state: synchroniser, prescaler, counter, output, flags, control.
    always_ff @(posedge XCLK_I) begin
      if (RST) begin
        data_q     <= '0;
        cnt_q      <= '0;
        ctrl_q     <= 4'b0000;
        one_shot_q <= 1'b0;
        psc_q      <= 8'd0;
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        prev_q     <= 1'b0;
        t_o_q      <= 1'b0;
        pulse_q    <= 1'b0;
        irq_q      <= 1'b0;
      end else begin
        sync1_q <= T_I[k];
        sync2_q <= sync1_q;
        prev_q  <= sync2_q;

        if (stopped) begin
          psc_q <= 8'd0;
        end else if (psc_run) begin
          psc_q <= tick ? 8'd0 : psc_q + 8'd1;
        end

        if (DAT_WE && sel_hit) begin
          data_q <= DAT_I;
        end

        if (terminal) begin
          cnt_q <= reload;
        end else if (step) begin
          cnt_q <= cnt_q - W'(1);
        end else if (DAT_WE && sel_hit && stopped) begin
          cnt_q <= DAT_I;
        end

        pulse_q <= terminal;

        // Forcing the output low beats a toggle in the same cycle.
        if (CTRL_WE && sel_hit && CTRL_I[4]) begin
          t_o_q <= 1'b0;
        end else if (terminal) begin
          t_o_q <= !t_o_q;
        end

        // A new terminal count beats an acknowledge in the same cycle.
        if (terminal) begin
          irq_q <= 1'b1;
        end else if (IACK && sel_hit) begin
          irq_q <= 1'b0;
        end

        if (CTRL_WE && sel_hit) begin
          ctrl_q     <= CTRL_I[3:0];
          one_shot_q <= CTRL_I[5];
        end else if (terminal && one_shot_q) begin
          ctrl_q <= 4'b0000;
        end
      end
    end

    assign cnt_vec[k]            = cnt_q;
    assign ctrl_vec[k]           = ctrl_q;
    assign os_vec[k]             = one_shot_q;
    assign pulse_vec[k]          = pulse_q;
    assign T_O[k]                = t_o_q;
    assign IRQ_PEND[k]           = irq_q;
    assign DELAY_MODE[k]         = !ctrl_q[3];
    assign SET_DATA_OUT[k*W +: W] = data_q;
  end

  assign T_O_PULSE = pulse_vec;

  // Read-side mux: the selected channel's counter and control (unused SEL codes read 0).
  always_comb begin
    sel_cnt = '0;
    CTRL_O  = 5'b00000;
    for (int i = 0; i < CHANNELS; i++) begin
      if (SEL == SEL_W'(i)) begin
        sel_cnt = cnt_vec[i];
        CTRL_O  = {os_vec[i], ctrl_vec[i]};
      end
    end
  end

  // Counter snapshot register: captures the pre-update count on RD_LATCH.
  always_ff @(posedge XCLK_I) begin
    if (RST) begin
      DAT_O <= '0;
    end else if (RD_LATCH) begin
      DAT_O <= sel_cnt;
    end
  end

endmodule

// File: tb/tb_mfp_timer_bank.sv
// Testbench for mfp_timer_bank (4 channels, 8-bit, cascading enabled).
// Expected terminal pulses are queued as (cycle*8 + channel) and are checked
// by a monitor. Register and flag expectations are hand-computed constants.
module tb_mfp_timer_bank;
  localparam int CH    = 4;
  localparam int W     = 8;
  localparam int SEL_W = 2;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [SEL_W-1:0]  sel = '0;
  logic              dat_we = 1'b0;
  logic [W-1:0]      dat_i = '0;
  logic              ctrl_we = 1'b0;
  logic [5:0]        ctrl_i = '0;
  logic [4:0]        ctrl_o;
  logic              rd_latch = 1'b0;
  logic [W-1:0]      dat_o;
  logic              iack = 1'b0;
  logic [CH-1:0]     t_i = '0;
  logic [CH-1:0]     t_o;
  logic [CH-1:0]     t_o_pulse;
  logic [CH-1:0]     irq_pend;
  logic [CH-1:0]     delay_mode;
  logic [CH*W-1:0]   set_data_out;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mfp_timer_bank #(
    .CHANNELS(CH), .W(W), .CASCADE(1), .SEL_W(SEL_W)
  ) dut (
    .XCLK_I(clk), .RST(rst), .SEL(sel), .DAT_WE(dat_we), .DAT_I(dat_i),
    .CTRL_WE(ctrl_we), .CTRL_I(ctrl_i), .CTRL_O(ctrl_o), .RD_LATCH(rd_latch),
    .DAT_O(dat_o), .IACK(iack), .T_I(t_i), .T_O(t_o), .T_O_PULSE(t_o_pulse),
    .IRQ_PEND(irq_pend), .DELAY_MODE(delay_mode), .SET_DATA_OUT(set_data_out)
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int ch, input int at);
    logic [31:0] key;
    int idx;
    key = 32'(at * 8 + ch);
    idx = 0;
    while (idx < exp_q.size() && exp_q[idx] <= key) idx++;
    exp_q.insert(idx, key);
  endtask

  // Monitor: every terminal pulse must match the next expected (cycle, channel).
  always @(negedge clk) begin
    logic [31:0] got;
    logic [31:0] exp_k;
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        if (t_o_pulse[c]) begin
          got = 32'(cyc * 8 + c);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pulse_unexpected: ch%0d at cycle %0d, none expected", c, cyc);
          end else begin
            exp_k = exp_q.pop_front();
            if (exp_k !== got) begin
              n_fail++;
              $display("FAIL pulse_timing: got ch%0d@%0d expected ch%0d@%0d",
                       c, cyc, exp_k % 8, exp_k / 8);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic wr_dat(input int ch, input logic [W-1:0] v);
    sel = SEL_W'(ch); dat_i = v; dat_we = 1'b1;
    @(negedge clk);
    dat_we = 1'b0;
  endtask

  task automatic wr_ctrl(input int ch, input logic [5:0] v);
    sel = SEL_W'(ch); ctrl_i = v; ctrl_we = 1'b1;
    @(negedge clk);
    ctrl_we = 1'b0;
  endtask

  task automatic strobe_rd(input int ch);
    sel = SEL_W'(ch); rd_latch = 1'b1;
    @(negedge clk);
    rd_latch = 1'b0;
  endtask

  task automatic strobe_iack(input int ch);
    sel = SEL_W'(ch); iack = 1'b1;
    @(negedge clk);
    iack = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_t_o", 32'(t_o), 0);
    chk("rst_pulse", 32'(t_o_pulse), 0);
    chk("rst_irq", 32'(irq_pend), 0);
    chk("rst_delay_mode", 32'(delay_mode), 32'hF);
    chk("rst_set_data", set_data_out, 0);
    chk("rst_dat_o", 32'(dat_o), 0);
    chk("rst_ctrl_o", 32'(ctrl_o), 0);

    // Delay mode: data 3, prescale 4 -> pulse every 12 cycles
    wr_dat(0, 8'd3);
    wr_ctrl(0, 6'b000001);
    t0 = cyc;
    expect_pulse(0, t0 + 12);
    expect_pulse(0, t0 + 24);
    wait_until(t0 + 3);
    strobe_rd(0);
    chk("rd_pre_edge", 32'(dat_o), 3);
    wait_until(t0 + 12);
    chk("delay_t_o_1", 32'(t_o[0]), 1);
    chk("delay_irq_1", 32'(irq_pend[0]), 1);
    strobe_iack(0);
    chk("iack_clear", 32'(irq_pend[0]), 0);
    wait_until(t0 + 24);
    chk("delay_t_o_2", 32'(t_o[0]), 0);
    chk("delay_irq_2", 32'(irq_pend[0]), 1);
    wr_ctrl(0, 6'b000000);
    strobe_iack(0);

    // One-shot on ch1: data 2, prescale 4 -> single pulse after 8 cycles
    wr_dat(1, 8'd2);
    wr_ctrl(1, 6'b100001);
    t0 = cyc;
    chk("oneshot_ctrl_o_run", 32'(ctrl_o), 32'b10001);
    expect_pulse(1, t0 + 8);
    wait_until(t0 + 8);
    chk("oneshot_ctrl_o_done", 32'(ctrl_o), 32'b10000);
    chk("oneshot_irq", 32'(irq_pend[1]), 1);
    strobe_rd(1);
    chk("oneshot_readback", 32'(dat_o), 2);
    wait_until(t0 + 20);
    strobe_iack(1);

    // Cascade: ch0 delay data 1 (pulse every 4), ch1 event data 5 -> every 20
    wr_dat(1, 8'd5);
    wr_ctrl(1, 6'b001000);
    chk("event_delay_mode", 32'(delay_mode[1]), 0);
    wr_dat(0, 8'd1);
    wr_ctrl(0, 6'b000001);
    t0 = cyc;
    for (int k = 1; k <= 10; k++) expect_pulse(0, t0 + 4 * k);
    expect_pulse(1, t0 + 21);
    expect_pulse(1, t0 + 41);
    while (cyc < t0 + 42) begin
      t_i[1] = ~t_i[1];
      @(negedge clk);
    end
    t_i[1] = 1'b0;
    wr_ctrl(0, 6'b000000);
    wr_ctrl(1, 6'b000000);
    strobe_rd(1);
    chk("cascade_readback", 32'(dat_o), 5);
    strobe_iack(0);
    strobe_iack(1);

    // Pulse mode on ch2: gate high for 10 cycles -> two ticks, 5 -> 3
    wr_dat(2, 8'd5);
    wr_ctrl(2, 6'b001001);
    chk("pulse_delay_mode", 32'(delay_mode[2]), 0);
    t_i[2] = 1'b1;
    repeat (10) @(negedge clk);
    t_i[2] = 1'b0;
    repeat (6) @(negedge clk);
    strobe_rd(2);
    chk("pulse_readback", 32'(dat_o), 3);
    chk("pulse_no_irq", 32'(irq_pend[2]), 0);
    wr_ctrl(2, 6'b000000);

    // Force-low wins over toggle; then DAT_WE on terminal count reloads 9
    wr_dat(3, 8'd1);
    wr_ctrl(3, 6'b000001);
    t0 = cyc;
    expect_pulse(3, t0 + 4);
    expect_pulse(3, t0 + 8);
    wait_until(t0 + 3);
    wr_ctrl(3, 6'b010001);
    chk("force_low_t_o", 32'(t_o[3]), 0);
    chk("force_low_irq", 32'(irq_pend[3]), 1);
    wait_until(t0 + 7);
    wr_dat(3, 8'd9);
    chk("reload_t_o", 32'(t_o[3]), 1);
    wr_ctrl(3, 6'b000000);
    strobe_rd(3);
    chk("reload_new_data", 32'(dat_o), 9);
    chk("set_data_out", set_data_out, 32'h09050501);

    // Event mode with data 0: 256 edges to terminal count
    wr_dat(0, 8'd0);
    wr_ctrl(0, 6'b001000);
    for (int i = 0; i < 256; i++) begin
      t_i[0] = 1'b1;
      if (i == 255) expect_pulse(0, cyc + 3);
      @(negedge clk);
      t_i[0] = 1'b0;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("event256_irq", 32'(irq_pend[0]), 1);
    wr_ctrl(0, 6'b000000);

    // Reset in the middle of a running count
    wr_dat(0, 8'd3);
    wr_ctrl(0, 6'b000001);
    strobe_rd(3);
    sel = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_t_o", 32'(t_o), 0);
    chk("midrst_irq", 32'(irq_pend), 0);
    chk("midrst_delay_mode", 32'(delay_mode), 32'hF);
    chk("midrst_set_data", set_data_out, 0);
    chk("midrst_dat_o", 32'(dat_o), 0);
    chk("midrst_ctrl_o", 32'(ctrl_o), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    chk("pulses_outstanding", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
